// File: rtl/cache_way_controller.sv
// cache_way_controller
// Set-level controller for one cache set. It takes CPU requests, resolves
// hit/miss from the per-way status, runs write-back and refill against the
// next memory level, and drives the allocate/write/age strobes to the ways.
module cache_way_controller #(
  parameter int NUM_WAYS      = 8,
  parameter int COUNTER_WIDTH = $clog2(NUM_WAYS),
  parameter int DATA_WIDTH    = 32,
  parameter int BLOCK_SIZE    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                                                        clk,
  input  logic                                                        reset_n,
  // CPU request / response
  input  logic                                                        req_valid,
  output logic                                                        req_ready,
  input  logic                                                        req_write,
  input  logic [ADDRESS_WIDTH-1:0]                                    req_addr,
  input  logic [DATA_WIDTH-1:0]                                       req_wdata,
  output logic                                                        rsp_valid,
  output logic                                                        rsp_hit,
  output logic [DATA_WIDTH-1:0]                                       rsp_rdata,
  // Per-way status from the way array
  input  logic [NUM_WAYS-1:0]                                         way_hit,
  input  logic [NUM_WAYS-1:0]                                         way_valid,
  input  logic [NUM_WAYS-1:0]                                         way_dirty,
  input  logic [NUM_WAYS-1:0]                                         way_expired,
  input  logic [NUM_WAYS*COUNTER_WIDTH-1:0]                           way_age,
  input  logic [NUM_WAYS*(ADDRESS_WIDTH-$clog2(BLOCK_SIZE))-1:0]      way_tag,
  input  logic [NUM_WAYS*DATA_WIDTH-1:0]                              way_data_out,
  // Control towards the way array
  output logic [ADDRESS_WIDTH-1:0]                                    way_address,
  output logic [DATA_WIDTH-1:0]                                       way_data_in,
  output logic [NUM_WAYS-1:0]                                         way_allocate,
  output logic [NUM_WAYS-1:0]                                         way_wen,
  output logic                                                        way_accessed,
  output logic [COUNTER_WIDTH-1:0]                                    way_accessed_age,
  // Next memory level
  output logic                                                        mem_req_valid,
  input  logic                                                        mem_req_ready,
  output logic                                                        mem_req_write,
  output logic [ADDRESS_WIDTH-1:0]                                    mem_req_addr,
  output logic [DATA_WIDTH-1:0]                                       mem_req_wdata,
  input  logic                                                        mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]                                       mem_rsp_data
);

  localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE);
  localparam int TAG_WIDTH    = ADDRESS_WIDTH - OFFSET_WIDTH;
  localparam int IDX_WIDTH    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WB        = 3'd2,
    S_FILL_REQ  = 3'd3,
    S_FILL_WAIT = 3'd4,
    S_ALLOC     = 3'd5,
    S_WRITE     = 3'd6,
    S_RESP      = 3'd7
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     write_q, write_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [IDX_WIDTH-1:0]     victim_idx_q, victim_idx_d;
  logic [TAG_WIDTH-1:0]     victim_tag_q, victim_tag_d;
  logic [DATA_WIDTH-1:0]    victim_data_q, victim_data_d;
  logic [COUNTER_WIDTH-1:0] victim_age_q, victim_age_d;
  logic                     hit_q, hit_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;

  // Unpacked views of the packed per-way buses
  logic [COUNTER_WIDTH-1:0] age_arr  [NUM_WAYS];
  logic [TAG_WIDTH-1:0]     tag_arr  [NUM_WAYS];
  logic [DATA_WIDTH-1:0]    data_arr [NUM_WAYS];

  generate
    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_unpack
      assign age_arr[gi]  = way_age[gi*COUNTER_WIDTH +: COUNTER_WIDTH];
      assign tag_arr[gi]  = way_tag[gi*TAG_WIDTH +: TAG_WIDTH];
      assign data_arr[gi] = way_data_out[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // One-hot strobe for a single way index
  function automatic logic [NUM_WAYS-1:0] onehot(input logic [IDX_WIDTH-1:0] idx);
    logic [NUM_WAYS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  logic                 any_hit;
  logic [IDX_WIDTH-1:0] hit_idx;
  logic                 any_expired;
  logic [IDX_WIDTH-1:0] expired_idx;
  logic [IDX_WIDTH-1:0] victim_idx;

  // Lowest-index priority encode of the hit and expired vectors
  always_comb begin
    any_hit     = 1'b0;
    hit_idx     = '0;
    any_expired = 1'b0;
    expired_idx = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (way_hit[i]) begin
        any_hit = 1'b1;
        hit_idx = IDX_WIDTH'(i);
      end
      if (way_expired[i]) begin
        any_expired = 1'b1;
        expired_idx = IDX_WIDTH'(i);
      end
    end
    // With nothing expired the last way is evicted
    victim_idx = any_expired ? expired_idx : IDX_WIDTH'(NUM_WAYS - 1);
  end

  // State register and transaction latches
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      victim_idx_q  <= '0;
      victim_tag_q  <= '0;
      victim_data_q <= '0;
      victim_age_q  <= '0;
      hit_q         <= 1'b0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      write_q       <= write_d;
      wdata_q       <= wdata_d;
      victim_idx_q  <= victim_idx_d;
      victim_tag_q  <= victim_tag_d;
      victim_data_q <= victim_data_d;
      victim_age_q  <= victim_age_d;
      hit_q         <= hit_d;
      rdata_q       <= rdata_d;
    end
  end

  // Next-state, latch updates and all strobes, decoded from the current state
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    write_d       = write_q;
    wdata_d       = wdata_q;
    victim_idx_d  = victim_idx_q;
    victim_tag_d  = victim_tag_q;
    victim_data_d = victim_data_q;
    victim_age_d  = victim_age_q;
    hit_d         = hit_q;
    rdata_d       = rdata_q;

    req_ready        = 1'b0;
    rsp_valid        = 1'b0;
    rsp_hit          = 1'b0;
    rsp_rdata        = '0;
    way_address      = '0;
    way_data_in      = '0;
    way_allocate     = '0;
    way_wen          = '0;
    way_accessed     = 1'b0;
    way_accessed_age = '0;
    mem_req_valid    = 1'b0;
    mem_req_write    = 1'b0;
    mem_req_addr     = '0;
    mem_req_wdata    = '0;

    // The ways see the captured address for the whole transaction
    if (state_q != S_IDLE) begin
      way_address = addr_q;
    end

    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          write_d = req_write;
          wdata_d = req_wdata;
          state_d = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (any_hit) begin
          way_accessed     = 1'b1;
          way_accessed_age = age_arr[hit_idx];
          hit_d            = 1'b1;
          if (write_q) begin
            way_wen     = onehot(hit_idx);
            way_data_in = wdata_q;
            rdata_d     = '0;
          end else begin
            rdata_d = data_arr[hit_idx];
          end
          state_d = S_RESP;
        end else begin
          // Snapshot the victim so later status changes cannot disturb it
          victim_idx_d  = victim_idx;
          victim_tag_d  = tag_arr[victim_idx];
          victim_data_d = data_arr[victim_idx];
          victim_age_d  = age_arr[victim_idx];
          hit_d         = 1'b0;
          rdata_d       = '0;
          if (way_valid[victim_idx] && way_dirty[victim_idx]) begin
            state_d = S_WB;
          end else if (write_q) begin
            state_d = S_ALLOC;
          end else begin
            state_d = S_FILL_REQ;
          end
        end
      end

      S_WB: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {victim_tag_q, {OFFSET_WIDTH{1'b0}}};
        mem_req_wdata = victim_data_q;
        if (mem_req_ready) begin
          state_d = write_q ? S_ALLOC : S_FILL_REQ;
        end
      end

      S_FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {addr_q[ADDRESS_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
        if (mem_req_ready) begin
          state_d = S_FILL_WAIT;
        end
      end

      S_FILL_WAIT: begin
        if (mem_rsp_valid) begin
          way_wen     = onehot(victim_idx_q);
          way_data_in = mem_rsp_data;
          rdata_d     = mem_rsp_data;
          state_d     = S_ALLOC;
        end
      end

      S_ALLOC: begin
        way_allocate     = onehot(victim_idx_q);
        way_accessed     = 1'b1;
        way_accessed_age = victim_age_q;
        state_d          = write_q ? S_WRITE : S_RESP;
      end

      S_WRITE: begin
        way_wen     = onehot(victim_idx_q);
        way_data_in = wdata_q;
        state_d     = S_RESP;
      end

      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_hit   = hit_q;
        rsp_rdata = rdata_q;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
